// File: rtl/pc_run_pkg.sv
// rtl/pc_run_pkg.sv - shared state type, default entry table and clog2 helper
// Purpose: common definitions for pc_run_sequencer and its timer.
// Contents: run_state_t, DEFAULT_ENTRY_PCS, clog2().
package pc_run_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESET = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } run_state_t;

  // Entry i lives at bits [i*32 +: 32]; entry 0 is the lowest word.
  localparam logic [127:0] DEFAULT_ENTRY_PCS =
    {32'h00400060, 32'h00400040, 32'h00400020, 32'h00400000};

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/run_timer.sv
// rtl/run_timer.sv - loadable up-counter with terminal-count flag
// Purpose: phase timer shared by the RESET and RUN phases of the sequencer.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   load/load_value synchronous load (wins over en)
//   en              increment by one
//   term            terminal value compared against count
//   count           current count
//   tc              count == term
module run_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         tc
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == term);

endmodule

// File: rtl/pc_run_sequencer.sv
// rtl/pc_run_sequencer.sv - run controller: reset, launch and watch the processor
// Purpose: on start, pick an entry PC, hold the processor in reset for
//   RESET_CYCLES, release it and wait for z == expect_z or a cycle budget.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   start, entry_sel, expect_z run request and its sampled arguments
//   abort                      cancel a run in RESET or RUN
//   z                          processor result bus
//   proc_reset, load_pc        processor control
//   busy, done                 phase status
//   pass, timeout, sel_err     result flags
//   cycles                     RUN cycles elapsed at match, MAX_CYCLES on timeout
module pc_run_sequencer
  import pc_run_pkg::*;
#(
  parameter int                            ADDR_W       = 32,
  parameter int                            DATA_W       = 32,
  parameter int                            NUM_ENTRIES  = 4,
  parameter logic [NUM_ENTRIES*ADDR_W-1:0] ENTRY_PCS    = DEFAULT_ENTRY_PCS,
  parameter int                            RESET_CYCLES = 2,
  parameter int                            MAX_CYCLES   = 16,
  localparam int SEL_W = (clog2(NUM_ENTRIES) > 1) ? clog2(NUM_ENTRIES) : 1,
  localparam int CNT_W = clog2(MAX_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [SEL_W-1:0]  entry_sel,
  input  logic [DATA_W-1:0] expect_z,
  input  logic              abort,
  input  logic [DATA_W-1:0] z,
  output logic              proc_reset,
  output logic [ADDR_W-1:0] load_pc,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic              sel_err,
  output logic [CNT_W-1:0]  cycles
);

  // The timer serves both phases, so it must hold the larger terminal value.
  localparam int TMAX = (RESET_CYCLES > MAX_CYCLES) ? RESET_CYCLES : MAX_CYCLES;
  localparam int TW   = clog2(TMAX + 1);

  run_state_t        state_q, state_d;
  logic [DATA_W-1:0] expect_q, expect_d;
  logic              proc_reset_d;
  logic [ADDR_W-1:0] load_pc_d;
  logic              busy_d, done_d, pass_d, timeout_d, sel_err_d;
  logic [CNT_W-1:0]  cycles_d;

  logic              tmr_load, tmr_en, tmr_tc;
  logic [TW-1:0]     tmr_term, tmr_count;

  logic [ADDR_W-1:0] pc_pick;
  logic              sel_bad;

  run_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (tmr_load),
    .load_value ('0),
    .en         (tmr_en),
    .term       (tmr_term),
    .count      (tmr_count),
    .tc         (tmr_tc)
  );

  always_comb begin
    pc_pick = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (entry_sel == SEL_W'(i)) begin
        pc_pick = ENTRY_PCS[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // One extra bit so NUM_ENTRIES == 2**SEL_W still compares correctly.
  assign sel_bad = ({1'b0, entry_sel} >= (SEL_W + 1)'(NUM_ENTRIES));

  always_comb begin
    state_d      = state_q;
    expect_d     = expect_q;
    proc_reset_d = proc_reset;
    load_pc_d    = load_pc;
    pass_d       = pass;
    timeout_d    = timeout;
    sel_err_d    = sel_err;
    cycles_d     = cycles;
    tmr_load     = 1'b0;
    tmr_en       = 1'b0;
    tmr_term     = TW'(RESET_CYCLES - 1);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (sel_bad) begin
            sel_err_d = 1'b1;
            pass_d    = 1'b0;
            timeout_d = 1'b0;
            state_d   = DONE;
          end else begin
            load_pc_d    = pc_pick;
            expect_d     = expect_z;
            pass_d       = 1'b0;
            timeout_d    = 1'b0;
            sel_err_d    = 1'b0;
            cycles_d     = '0;
            proc_reset_d = 1'b1;
            tmr_load     = 1'b1;
            state_d      = RESET;
          end
        end
      end

      RESET: begin
        if (abort) begin
          proc_reset_d = 1'b1;
          pass_d       = 1'b0;
          timeout_d    = 1'b0;
          cycles_d     = '0;
          state_d      = IDLE;
        end else if (tmr_tc) begin
          // Count value k is seen on the (k+1)th edge in RESET, so release
          // lands exactly RESET_CYCLES edges after start.
          proc_reset_d = 1'b0;
          tmr_load     = 1'b1;
          state_d      = RUN;
        end else begin
          tmr_en = 1'b1;
        end
      end

      RUN: begin
        tmr_term = TW'(MAX_CYCLES - 1);
        if (abort) begin
          proc_reset_d = 1'b1;
          pass_d       = 1'b0;
          timeout_d    = 1'b0;
          cycles_d     = '0;
          state_d      = IDLE;
        end else if (z == expect_q) begin
          pass_d       = 1'b1;
          cycles_d     = CNT_W'(tmr_count);
          proc_reset_d = 1'b1;
          state_d      = DONE;
        end else if (tmr_tc) begin
          timeout_d    = 1'b1;
          cycles_d     = CNT_W'(MAX_CYCLES);
          proc_reset_d = 1'b1;
          state_d      = DONE;
        end else begin
          tmr_en = 1'b1;
        end
      end

      default: begin
        proc_reset_d = 1'b1;
        state_d      = IDLE;
      end
    endcase
  end

  // Status flags are registered from the next state so they line up with it.
  assign busy_d = (state_d == RESET) || (state_d == RUN);
  assign done_d = (state_d == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      expect_q   <= '0;
      proc_reset <= 1'b1;
      load_pc    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
      sel_err    <= 1'b0;
      cycles     <= '0;
    end else begin
      state_q    <= state_d;
      expect_q   <= expect_d;
      proc_reset <= proc_reset_d;
      load_pc    <= load_pc_d;
      busy       <= busy_d;
      done       <= done_d;
      pass       <= pass_d;
      timeout    <= timeout_d;
      sel_err    <= sel_err_d;
      cycles     <= cycles_d;
    end
  end

endmodule

// File: tb/tb_pc_run_sequencer.sv
// tb/tb_pc_run_sequencer.sv - directed bench for pc_run_sequencer
module tb_pc_run_sequencer;

  localparam logic [31:0] P0 = 32'h00400000;
  localparam logic [31:0] P1 = 32'h00400020;
  localparam logic [31:0] P2 = 32'h00400040;
  localparam logic [31:0] P3 = 32'h00400060;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        start = 1'b0, abort = 1'b0;
  logic [1:0]  entry_sel = '0;
  logic [31:0] expect_z = '0, z = '0;
  logic        proc_reset, busy, done, pass, timeout, sel_err;
  logic [31:0] load_pc;
  logic [4:0]  cycles;

  logic        start1 = 1'b0, abort1 = 1'b0;
  logic [1:0]  sel1 = '0;
  logic [31:0] expect1 = '0, z1 = '0;
  logic        proc_reset1, busy1, done1, pass1, timeout1, sel_err1;
  logic [31:0] load_pc1;
  logic [4:0]  cycles1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_run_sequencer u0 (
    .clk(clk), .reset(reset), .start(start), .entry_sel(entry_sel),
    .expect_z(expect_z), .abort(abort), .z(z),
    .proc_reset(proc_reset), .load_pc(load_pc), .busy(busy), .done(done),
    .pass(pass), .timeout(timeout), .sel_err(sel_err), .cycles(cycles)
  );

  pc_run_sequencer #(
    .NUM_ENTRIES(3),
    .ENTRY_PCS({32'h00400040, 32'h00400020, 32'h00400000})
  ) u1 (
    .clk(clk), .reset(reset), .start(start1), .entry_sel(sel1),
    .expect_z(expect1), .abort(abort1), .z(z1),
    .proc_reset(proc_reset1), .load_pc(load_pc1), .busy(busy1), .done(done1),
    .pass(pass1), .timeout(timeout1), .sel_err(sel_err1), .cycles(cycles1)
  );

  wire [42:0] obs0 = {proc_reset, load_pc, busy, done, pass, timeout, sel_err, cycles};
  wire [42:0] obs1 = {proc_reset1, load_pc1, busy1, done1, pass1, timeout1, sel_err1, cycles1};

  typedef struct {
    logic        start;
    logic [1:0]  sel;
    logic [31:0] ez;
    logic        ab;
    logic [31:0] zz;
    logic [42:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [42:0] pk(input logic pr, input logic [31:0] pc,
                                     input logic b, input logic d, input logic p,
                                     input logic t, input logic se, input logic [4:0] cy);
    return {pr, pc, b, d, p, t, se, cy};
  endfunction

  task automatic add(input logic s, input logic [1:0] sel, input logic [31:0] ez,
                     input logic ab, input logic [31:0] zz,
                     input logic pr, input logic [31:0] pc, input logic b, input logic d,
                     input logic p, input logic t, input logic se, input logic [4:0] cy);
    vec_t v;
    v.start = s; v.sel = sel; v.ez = ez; v.ab = ab; v.zz = zz;
    v.exp = pk(pr, pc, b, d, p, t, se, cy);
    vecs.push_back(v);
  endtask

  // Fields: proc_reset load_pc busy done pass timeout sel_err cycles
  task automatic chk(input string name, input logic [42:0] act, input logic [42:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got pr=%b pc=%h b=%b d=%b p=%b t=%b se=%b cy=%0d, expected pr=%b pc=%h b=%b d=%b p=%b t=%b se=%b cy=%0d",
               name, act[42], act[41:10], act[9], act[8], act[7], act[6], act[5], act[4:0],
               exp[42], exp[41:10], exp[9], exp[8], exp[7], exp[6], exp[5], exp[4:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Sequence A: match on 3rd RUN cycle, then abort ignored in DONE
    add(1, 2, 32'h5, 0, 0,      1, P2, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0,     0, 0,      1, P2, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0,     0, 0,      0, P2, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0,     0, 0,      0, P2, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0,     0, 0,      0, P2, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0,     0, 32'h5,  1, P2, 0, 1, 1, 0, 0, 2);
    add(0, 0, 0,     1, 32'h5,  1, P2, 0, 1, 1, 0, 0, 2);
    // Sequence B: never matches, times out after 2+16 edges
    add(1, 0, 32'hFFFF, 0, 0,   1, P0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0,        0, 0,   1, P0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) add(0, 0, 0, 0, 0, 0, P0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0,        0, 0,   1, P0, 0, 1, 0, 1, 0, 16);
    // Sequence C: match on the last budget cycle beats timeout
    add(1, 3, 32'h33, 0, 0,     1, P3, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0,      0, 0,     1, P3, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) add(0, 0, 0, 0, 0, 0, P3, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0,      0, 32'h33, 1, P3, 0, 1, 1, 0, 0, 15);
    // Sequence D: abort during RESET
    add(1, 1, 32'h1, 0, 0,      1, P1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0,     1, 0,      1, P1, 0, 0, 0, 0, 0, 0);
    // Sequence E: abort on 4th RUN cycle while z matches
    add(1, 3, 32'h77, 0, 0,     1, P3, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0,      0, 0,     1, P3, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, P3, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0,      1, 32'h77, 1, P3, 0, 0, 0, 0, 0, 0);
    // Sequence F: start while busy ignored, start in DONE relaunches
    add(1, 2, 32'h9, 0, 0,      1, P2, 1, 0, 0, 0, 0, 0);
    add(1, 3, 0,     0, 0,      1, P2, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0,     0, 0,      0, P2, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0,     0, 32'h9,  1, P2, 0, 1, 1, 0, 0, 0);
    add(1, 1, 32'hA, 0, 32'h9,  1, P1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0,     0, 0,      1, P1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0,     0, 0,      0, P1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0,     0, 0,      0, P1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0,     0, 32'hA,  1, P1, 0, 1, 1, 0, 0, 1);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset_u0", obs0, pk(1, 0, 0, 0, 0, 0, 0, 0));
    chk("reset_u1", obs1, pk(1, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;

    // Out-of-range entry on the 3-entry instance
    start1 = 1'b1; sel1 = 2'd3;
    tick();
    chk("sel_err", obs1, pk(1, 0, 0, 1, 0, 0, 1, 0));
    start1 = 1'b0;
    tick();
    chk("sel_err_hold", obs1, pk(1, 0, 0, 1, 0, 0, 1, 0));
    start1 = 1'b1; sel1 = 2'd2;
    tick();
    chk("u1_last_entry", obs1, pk(1, P2, 1, 0, 0, 0, 0, 0));
    start1 = 1'b0; abort1 = 1'b1;
    tick();
    chk("u1_abort", obs1, pk(1, P2, 0, 0, 0, 0, 0, 0));
    abort1 = 1'b0;

    // Table-driven sequences on the default instance
    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].start; entry_sel = vecs[i].sel; expect_z = vecs[i].ez;
      abort = vecs[i].ab;    z = vecs[i].zz;
      tick();
      chk($sformatf("vec%0d", i), obs0, vecs[i].exp);
    end
    start = 1'b0; abort = 1'b0; z = '0; entry_sel = '0; expect_z = '0;

    // Asynchronous reset in the middle of RUN
    start = 1'b1; entry_sel = 2'd2; expect_z = 32'h1234;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("pre_reset_run", obs0, pk(0, P2, 1, 0, 0, 0, 0, 0));
    #2 reset = 1'b0;
    #1 chk("async_reset", obs0, pk(1, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1; entry_sel = 2'd1; expect_z = 32'h0;
    tick();
    chk("restart_after_reset", obs0, pk(1, P1, 1, 0, 0, 0, 0, 0));
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("restart_match_first", obs0, pk(1, P1, 0, 1, 1, 0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
